dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the 128-word data memory. Port A (CPU MEM stage) issues single-word accesses; port B (DMA/loader) issues bursts of 1..MAX_BURST consecutive words. The block sits between both requesters and the memory's Address/Write_Data/MemWrite/MemRead/Read_data pins. It grants round-robin, generates burst addresses, returns registered read data and flags out-of-range accesses.

## Interface

- MEM_WORDS, 128, memory depth in 32-bit words
- MAX_BURST, 16, longest port-B burst in words
- LEN_W, $clog2(MAX_BURST)+1, width of b_len

- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  synchronous, active-high reset
- a_req / a_we  in  1 / 1  port-A request / write (1) or read (0)
- a_addr / a_wdata  in  32 / 32  byte address (bits [1:0] ignored) / write data
- a_gnt  out  1  one-cycle pulse: request accepted, inputs latched
- a_rvalid / a_rdata  out  1 / 32  read response
- b_req / b_we  in  1 / 1  port-B burst request / direction
- b_addr / b_len  in  32 / LEN_W  burst base byte address / beat count
- b_wdata  in  32  write beat data, sampled while b_wready=1
- b_gnt / b_wready  out  1 / 1  burst accepted / write beat consumed this cycle
- b_rvalid / b_rdata  out  1 / 32  read beat response
- b_done / b_err  out  1 / 1  burst-end pulse / burst had an error
- Address / Write_Data  out  32 / 32  to memory
- MemWrite / MemRead  out  1 / 1  to memory
- Read_data  in  32  from memory (combinational)
- addr_err  out  1  pulse: a beat was suppressed for out-of-range word index

## Operation

- FSM states IDLE, A_XFER, B_BURST. Reset: state IDLE, last-grant = B (A wins first tie), all outputs 0.
- IDLE: only a_req → A_XFER with a_gnt; only b_req → B_BURST with b_gnt; both → grant the port not granted last. Grant edge latches addr, we, wdata (A) or addr, we, len (B).
- A_XFER: one memory cycle → IDLE. A port gets at most one access per two cycles.
- B_BURST: one beat per cycle. Address = base + 4·beat (32-bit wrap), beat counter 0..len-1. Write: b_wready=1 every beat cycle; Write_Data = b_wdata directly. Last beat → b_done pulse next cycle → IDLE.
- b_len=0 or >MAX_BURST: no memory access; b_gnt, then b_done=b_err=1 next cycle.
- Word index = Address>>2. Index ≥ MEM_WORDS: MemWrite/MemRead held 0, addr_err pulses. A read beat still returns rvalid with rdata=0. Any such beat sets b_err with b_done.
- MemRead/MemWrite are high only in access cycles; otherwise Address, Write_Data = 0.
- Requesters may drop req after gnt. A req held during the other port's burst waits; max wait is MAX_BURST+1 cycles.

## Timing

- Cycle N: req seen in IDLE. N+1: gnt and first access cycle.
- Write commits at the end of the access cycle. Read data is registered: rvalid/rdata in the cycle after each access.
- Burst of L beats: access cycles N+1..N+L, b_rvalid N+2..N+L+1, b_done at N+L+1. The next grant is decided at N+L+1, with its access at N+L+2.
- RESET mid-operation: next cycle IDLE, memory strobes low. No done/rvalid for the aborted transfer. Memory writes already committed stand.

## Structure

- Package dmem_arb_pkg: state enum {IDLE, A_XFER, B_BURST}, port enum {PORT_A, PORT_B}, MEM_WORDS and MAX_BURST defaults, word-index range check function.
- Sub-module dmem_burst_ctr: loads base/len, outputs current address, beat count and last flag; sync reset.

## Test plan

- After memory reset, A read at 0x4 → a_gnt at N+1, MemRead high at N+1, a_rvalid with a_rdata=21 at N+2.
- A write 0x8 ← 99, then A read 0x8 → a_rdata=99. Word 3 (0xC) still reads 54.
- B write burst base 0x40, len 4, b_wdata 1..4 → b_wready 4 cycles. Words 16..19 then read back 1,2,3,4. b_done at N+5, b_err=0.
- a_req and b_req together from reset → A granted first. A re-requests during a len-3 B burst → A granted the cycle after b_done.
- B read base 0x1F8, len 4 → beats 126,127 return memory data. Beats 128,129 give rdata=0 and addr_err pulses. b_err=1 with b_done.
- b_len=0 → no MemRead/MemWrite, b_done=b_err=1 at N+2. RESET asserted on beat 2 of a len-8 write → IDLE next cycle, words after beat 2 unchanged.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states, port ids,
// default geometry and the word-index range check.
package dmem_arb_pkg;

  localparam int unsigned MEM_WORDS_DEF = 128;
  localparam int unsigned MAX_BURST_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    A_XFER,
    B_BURST
  } arb_state_e;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_e;

  // Byte address -> word index, compared against the memory depth.
  function automatic logic word_in_range(input logic [31:0] addr, input int unsigned words);
    return ({2'b00, addr[31:2]} < words);
  endfunction

endpackage

// File: rtl/dmem_burst_ctr.sv
// Port-B burst sequencer: holds the current beat address, the beat index and
// flags the final beat of the loaded length.
module dmem_burst_ctr #(
  parameter int unsigned LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [31:0]      base,
  input  logic [LEN_W-1:0] len,
  output logic [31:0]      addr,
  output logic [LEN_W-1:0] beat,
  output logic             last
);

  logic [31:0]      addr_q;
  logic [LEN_W-1:0] beat_q;
  logic [LEN_W-1:0] len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      beat_q <= '0;
      len_q  <= '0;
    end else if (load) begin
      addr_q <= base;
      beat_q <= '0;
      len_q  <= len;
    end else if (advance) begin
      addr_q <= addr_q + 32'd4;
      beat_q <= beat_q + 1'b1;
    end
  end

  assign addr = addr_q;
  assign beat = beat_q;
  assign last = (beat_q == len_q - 1'b1);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between a single-word CPU port (A) and a burst DMA port
// (B) in front of the 128-word data memory, with registered read returns.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned LEN_W     = $clog2(MAX_BURST) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [31:0]      a_addr,
  input  logic [31:0]      a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [31:0]      a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [31:0]      b_addr,
  input  logic [LEN_W-1:0] b_len,
  input  logic [31:0]      b_wdata,
  output logic             b_gnt,
  output logic             b_wready,
  output logic             b_rvalid,
  output logic [31:0]      b_rdata,
  output logic             b_done,
  output logic             b_err,
  output logic [31:0]      Address,
  output logic [31:0]      Write_Data,
  output logic             MemWrite,
  output logic             MemRead,
  input  logic [31:0]      Read_data,
  output logic             addr_err
);

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_BURST);

  arb_state_e state_q;
  port_e      last_q;

  logic [31:0] a_addr_q, a_wdata_q;
  logic        a_we_q;
  logic        b_we_q, b_bad_q, b_err_acc_q;

  logic        a_gnt_q, b_gnt_q, a_rvalid_q, b_rvalid_q, b_done_q, b_err_q;
  logic [31:0] a_rdata_q, b_rdata_q;

  logic             grant_a, grant_b, bad_len;
  logic             a_acc, b_beat, access, acc_we, in_range, err_so_far;
  logic [31:0]      acc_addr, rd_data;
  logic [31:0]      ctr_addr;
  logic [LEN_W-1:0] ctr_beat;
  logic             ctr_last;

  dmem_burst_ctr #(
    .LEN_W(LEN_W)
  ) u_burst_ctr (
    .clk    (CLK),
    .rst    (RESET),
    .load   (grant_b),
    .advance(b_beat),
    .base   (b_addr),
    .len    (b_len),
    .addr   (ctr_addr),
    .beat   (ctr_beat),
    .last   (ctr_last)
  );

  // A wins a tie only when B held the previous grant.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == IDLE) begin
      grant_a = a_req && (!b_req || last_q == PORT_B);
      grant_b = b_req && !grant_a;
    end
  end

  assign bad_len  = (b_len == '0) || (b_len > MaxLen);
  assign a_acc    = (state_q == A_XFER);
  assign b_beat   = (state_q == B_BURST) && !b_bad_q;
  assign access   = a_acc || b_beat;
  assign acc_addr = a_acc ? a_addr_q : (b_beat ? ctr_addr : 32'd0);
  assign acc_we   = a_acc ? a_we_q : b_we_q;
  assign in_range = word_in_range(acc_addr, MEM_WORDS);
  assign rd_data  = in_range ? Read_data : 32'd0;

  assign Address    = access ? acc_addr : 32'd0;
  assign MemWrite   = access && acc_we && in_range;
  assign MemRead    = access && !acc_we && in_range;
  assign Write_Data = (a_acc && a_we_q) ? a_wdata_q :
                      (b_beat && b_we_q) ? b_wdata : 32'd0;
  assign addr_err   = access && !in_range;
  assign b_wready   = b_beat && b_we_q;

  // Error history restarts on the first beat of every burst.
  assign err_so_far = (ctr_beat == '0) ? 1'b0 : b_err_acc_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      last_q      <= PORT_B;
      a_addr_q    <= '0;
      a_wdata_q   <= '0;
      a_we_q      <= 1'b0;
      b_we_q      <= 1'b0;
      b_bad_q     <= 1'b0;
      b_err_acc_q <= 1'b0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rvalid_q  <= 1'b0;
      b_rdata_q   <= '0;
      b_done_q    <= 1'b0;
      b_err_q     <= 1'b0;
    end else begin
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      b_done_q   <= 1'b0;
      b_err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_a) begin
            state_q   <= A_XFER;
            last_q    <= PORT_A;
            a_gnt_q   <= 1'b1;
            a_addr_q  <= a_addr;
            a_we_q    <= a_we;
            a_wdata_q <= a_wdata;
          end else if (grant_b) begin
            state_q <= B_BURST;
            last_q  <= PORT_B;
            b_gnt_q <= 1'b1;
            b_we_q  <= b_we;
            b_bad_q <= bad_len;
          end
        end
        A_XFER: begin
          state_q <= IDLE;
          if (!a_we_q) begin
            a_rvalid_q <= 1'b1;
            a_rdata_q  <= rd_data;
          end
        end
        B_BURST: begin
          if (b_bad_q) begin
            state_q  <= IDLE;
            b_done_q <= 1'b1;
            b_err_q  <= 1'b1;
          end else begin
            if (!b_we_q) begin
              b_rvalid_q <= 1'b1;
              b_rdata_q  <= rd_data;
            end
            b_err_acc_q <= err_so_far || !in_range;
            if (ctr_last) begin
              state_q  <= IDLE;
              b_done_q <= 1'b1;
              b_err_q  <= err_so_far || !in_range;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_gnt    = a_gnt_q;
  assign a_rvalid = a_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_gnt    = b_gnt_q;
  assign b_rvalid = b_rvalid_q;
  assign b_rdata  = b_rdata_q;
  assign b_done   = b_done_q;
  assign b_err    = b_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 128-word memory attached.
module tb_dmem_arbiter;

  localparam int LEN_W = 5;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             a_req, a_we;
  logic [31:0]      a_addr, a_wdata;
  logic             a_gnt, a_rvalid;
  logic [31:0]      a_rdata;
  logic             b_req, b_we;
  logic [31:0]      b_addr, b_wdata;
  logic [LEN_W-1:0] b_len;
  logic             b_gnt, b_wready, b_rvalid, b_done, b_err;
  logic [31:0]      b_rdata;
  logic [31:0]      Address, Write_Data, Read_data;
  logic             MemWrite, MemRead, addr_err;

  logic [31:0] mem [128];
  logic        mem_init;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_arbiter u_dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_len     (b_len),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_wready  (b_wready),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .b_done    (b_done),
    .b_err     (b_err),
    .Address   (Address),
    .Write_Data(Write_Data),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Read_data (Read_data),
    .addr_err  (addr_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_val(input int i);
    if (i == 1) return 32'd21;
    if (i == 3) return 32'd54;
    return 32'(i * 3 + 7);
  endfunction

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
    end else if (MemWrite) begin
      mem[Address[8:2]] <= Write_Data;
    end
  end
  assign Read_data = mem[Address[8:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input bit init_mem);
    RESET = 1'b1;
    mem_init = init_mem;
    cyc();
    cyc();
    RESET = 1'b0;
    mem_init = 1'b0;
  endtask

  // Issue from an idle cycle; returns in the idle cycle after the response.
  task automatic a_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    a_req = 1'b1; a_we = 1'b0; a_addr = addr;
    cyc();
    check({tag, "_gnt"}, {31'd0, a_gnt & MemRead}, 32'd1);
    a_req = 1'b0;
    cyc();
    check({tag, "_rvalid"}, {31'd0, a_rvalid}, 32'd1);
    check({tag, "_rdata"}, a_rdata, exp);
  endtask

  task automatic a_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data;
    cyc();
    check({tag, "_gnt_we"}, {30'd0, a_gnt, MemWrite}, 32'd3);
    check({tag, "_wdata"}, Write_Data, data);
    a_req = 1'b0;
    cyc();
  endtask

  logic [31:0] exp_rd [4] = '{32'd385, 32'd388, 32'd0, 32'd0};
  logic [3:0]  exp_fl [4] = '{4'b1000, 4'b0100, 4'b0100, 4'b0011};
  logic [LEN_W-1:0] bad_lens [2] = '{5'd0, 5'd17};

  initial begin
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_len = 0; b_wdata = 0;
    do_reset(1'b1);

    check("reset_outs", {22'd0, a_gnt, a_rvalid, b_gnt, b_wready, b_rvalid, b_done, b_err,
                         MemWrite, MemRead, addr_err}, 32'd0);
    check("reset_addr", Address, 32'd0);

    // Basic A read, then write/readback.
    a_req = 1'b1; a_addr = 32'h4;
    cyc();
    check("a_rd_gnt", {31'd0, a_gnt}, 32'd1);
    check("a_rd_memread", {31'd0, MemRead}, 32'd1);
    check("a_rd_addr", Address, 32'h4);
    a_req = 1'b0;
    cyc();
    check("a_rd_rvalid", {31'd0, a_rvalid}, 32'd1);
    check("a_rd_rdata", a_rdata, 32'd21);
    a_write("a_wr8", 32'h8, 32'd99);
    a_read("a_rd8", 32'h8, 32'd99);
    a_read("a_rdC", 32'hC, 32'd54);

    // B write burst of 4 at word 16.
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h40; b_len = 5'd4;
    for (int i = 0; i < 4; i++) begin
      cyc();
      b_req = 1'b0;
      b_wdata = 32'(i + 1);
      #1;
      if (i == 0) check("bw_gnt", {31'd0, b_gnt}, 32'd1);
      check("bw_wready", {30'd0, b_wready, MemWrite}, 32'd3);
      check("bw_addr", Address, 32'h40 + 32'(4 * i));
      check("bw_wdata", Write_Data, 32'(i + 1));
    end
    cyc();
    check("bw_done_err", {30'd0, b_done, b_err}, 32'd2);
    check("bw_wready_off", {31'd0, b_wready}, 32'd0);
    for (int i = 0; i < 4; i++) a_read("bw_rb", 32'h40 + 32'(4 * i), 32'(i + 1));

    // Simultaneous requests from reset, then A waits out a len-3 burst.
    do_reset(1'b1);
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h4;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h0; b_len = 5'd3;
    cyc();
    check("tie_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
    a_req = 1'b0;
    cyc();
    check("tie_a_rdata", a_rdata, 32'd21);
    check("tie_b_wait", {31'd0, b_gnt}, 32'd0);
    a_req = 1'b1; a_addr = 32'hC;
    cyc();
    check("rr_b_gnt", {30'd0, a_gnt, b_gnt}, 32'd1);
    b_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rr_b_rvalid", {31'd0, b_rvalid}, 32'd1);
      check("rr_b_rdata", b_rdata, init_val(i));
      check("rr_a_wait", {31'd0, a_gnt}, 32'd0);
    end
    check("rr_b_done", {31'd0, b_done}, 32'd1);
    cyc();
    check("rr_a_gnt", {30'd0, a_gnt, MemRead}, 32'd3);
    check("rr_a_addr", Address, 32'hC);
    a_req = 1'b0;
    cyc();
    check("rr_a_rdata", a_rdata, 32'd54);

    // B read burst straddling the top of memory.
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h1F8; b_len = 5'd4;
    cyc();
    check("oor_gnt", {29'd0, b_gnt, MemRead, addr_err}, 32'd6);
    b_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("oor_rvalid", {31'd0, b_rvalid}, 32'd1);
      check("oor_rdata", b_rdata, exp_rd[k]);
      check("oor_flags", {28'd0, MemRead, addr_err, b_done, b_err}, {28'd0, exp_fl[k]});
    end

    // Illegal lengths: grant, no access, done+err.
    for (int j = 0; j < 2; j++) begin
      b_req = 1'b1; b_we = 1'b1; b_addr = 32'h0; b_len = bad_lens[j];
      cyc();
      check("badlen_gnt", {28'd0, b_gnt, MemRead, MemWrite, b_wready}, 32'd8);
      b_req = 1'b0;
      cyc();
      check("badlen_done_err", {30'd0, b_done, b_err}, 32'd3);
    end

    // Reset during beat 2 of a len-8 write at word 64.
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h100; b_len = 5'd8;
    for (int i = 0; i < 3; i++) begin
      cyc();
      b_req = 1'b0;
      b_wdata = 32'hA0 + 32'(i);
      if (i == 2) RESET = 1'b1;
      #1;
      check("rst_beat_addr", Address, 32'h100 + 32'(4 * i));
    end
    cyc();
    RESET = 1'b0;
    #1;
    check("rst_idle", {27'd0, MemWrite, MemRead, b_wready, b_rvalid, b_done}, 32'd0);
    cyc();
    check("rst_no_done", {30'd0, b_done, MemWrite}, 32'd0);
    a_read("rst_w64", 32'h100, 32'hA0);
    a_read("rst_w65", 32'h104, 32'hA1);
    for (int i = 67; i < 72; i++) a_read("rst_keep", 32'(i * 4), init_val(i));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
